// File: rtl/midi_message_tx_pkg.sv
// Shared MIDI types, constants and helpers for the MIDI OUT transmitter.
package midi_message_tx_pkg;

    localparam int BAUD_RATE      = 31250;
    localparam int CHANNEL_WIDTH  = 4;
    localparam int STATUS_BIT_POS = 7;

    typedef logic [7:0] midi_byte_t;

    typedef enum logic [3:0] {
        NOTE_OFF            = 4'h8,
        NOTE_ON             = 4'h9,
        POLYPHONIC_PRESSURE = 4'hA,
        CONTROL_CHANGE      = 4'hB,
        PROGRAM_CHANGE      = 4'hC,
        CHANNEL_PRESSURE    = 4'hD,
        PITCH_BEND          = 4'hE,
        SYSTEM              = 4'hF
    } message_type_t;

    typedef struct packed {
        message_type_t message_type;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_SEND} seq_state_t;
    typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;

    function automatic logic [1:0] data_byte_count(input message_type_t t);
        case (t)
            NOTE_OFF, NOTE_ON, POLYPHONIC_PRESSURE,
            CONTROL_CHANGE, PITCH_BEND:         return 2'd2;
            PROGRAM_CHANGE, CHANNEL_PRESSURE:   return 2'd1;
            SYSTEM:                             return 2'd0;
            default:                            return 2'd0;
        endcase
    endfunction

    // Data bytes never carry the status flag.
    function automatic midi_byte_t to_data_byte(input logic [6:0] d);
        midi_byte_t b;
        b = {1'b0, d};
        b[STATUS_BIT_POS] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 byte serialiser, LSB first, idle high; each bit lasts DIV clocks.
module midi_uart_tx
    import midi_message_tx_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  midi_byte_t byte_data,
    output logic       tx
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    uart_state_t   state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_r, bit_s;
    midi_byte_t    shreg_r, shreg_s;
    logic          tx_r, tx_s;
    logic          bit_end_s;

    assign bit_end_s  = (cnt_r == {CW{1'b0}});
    // Accepting during the final stop cycle lets bytes run back-to-back.
    assign byte_ready = (state_r == UART_IDLE) || ((state_r == UART_STOP) && bit_end_s);
    assign tx         = tx_r;

    // Next-state, bit counter and line level for the serialiser.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shreg_s = shreg_r;
        tx_s    = tx_r;
        case (state_r)
            UART_IDLE: begin
                if (byte_valid) begin
                    state_s = UART_START;
                    cnt_s   = RELOAD;
                    bit_s   = 3'd0;
                    shreg_s = byte_data;
                    tx_s    = 1'b0;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            UART_START: begin
                if (bit_end_s) begin
                    state_s = UART_DATA;
                    cnt_s   = RELOAD;
                    bit_s   = 3'd0;
                    tx_s    = shreg_r[0];
                end else begin
                    cnt_s   = cnt_r - ONE;
                end
            end
            UART_DATA: begin
                if (bit_end_s) begin
                    cnt_s = RELOAD;
                    if (bit_r == 3'd7) begin
                        state_s = UART_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        tx_s    = shreg_r[bit_r + 3'd1];
                    end
                end else begin
                    cnt_s = cnt_r - ONE;
                end
            end
            UART_STOP: begin
                if (bit_end_s) begin
                    if (byte_valid) begin
                        state_s = UART_START;
                        cnt_s   = RELOAD;
                        bit_s   = 3'd0;
                        shreg_s = byte_data;
                        tx_s    = 1'b0;
                    end else begin
                        state_s = UART_IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r - ONE;
                end
            end
            default: begin
                state_s = UART_IDLE;
                tx_s    = 1'b1;
            end
        endcase
    end

    // Serialiser state register; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= UART_IDLE;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            shreg_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shreg_r <= shreg_s;
            tx_r    <= tx_s;
        end
    end

endmodule

// File: rtl/midi_message_tx.sv
// MIDI OUT: registers one message per handshake and sequences its status/data bytes into the UART.
module midi_message_tx
    import midi_message_tx_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int RUNNING_STATUS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     msg_valid,
    output logic                     msg_ready,
    input  message_t                 message,
    input  logic [CHANNEL_WIDTH-1:0] channel,
    output logic                     tx,
    output logic                     busy
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;

    seq_state_t               state_r, state_s;
    message_t                 msg_r;
    logic [CHANNEL_WIDTH-1:0] chan_r;
    logic [1:0]               pend_r, pend_s;
    logic                     rs_valid_r, rs_valid_s;
    midi_byte_t               rs_byte_r, rs_byte_s;
    logic                     ready_r, busy_r;

    midi_byte_t               status_s, byte_data_s;
    logic [1:0]               count_s;
    logic                     send_status_s, byte_valid_s, byte_ready_s;

    assign status_s      = {msg_r.message_type, chan_r};
    assign count_s       = data_byte_count(msg_r.message_type);
    assign send_status_s = !((RUNNING_STATUS != 0) && rs_valid_r && (rs_byte_r == status_s))
                           || (count_s == 2'd0);
    assign msg_ready     = ready_r;
    assign busy          = busy_r;

    // Byte sequencer: picks status/data bytes and tracks running status.
    always_comb begin
        state_s      = state_r;
        pend_s       = pend_r;
        rs_valid_s   = rs_valid_r;
        rs_byte_s    = rs_byte_r;
        byte_valid_s = 1'b0;
        byte_data_s  = to_data_byte(msg_r.data_byte1);
        case (state_r)
            SEQ_IDLE: begin
                if (msg_valid) begin
                    state_s = SEQ_LOAD;
                end else begin
                    state_s = SEQ_IDLE;
                end
            end
            SEQ_LOAD: begin
                byte_valid_s = 1'b1;
                state_s      = SEQ_SEND;
                if (send_status_s) begin
                    byte_data_s = status_s;
                    pend_s      = count_s;
                end else begin
                    byte_data_s = to_data_byte(msg_r.data_byte1);
                    pend_s      = count_s - 2'd1;
                end
                if ((RUNNING_STATUS == 0) || (msg_r.message_type == SYSTEM)) begin
                    rs_valid_s = 1'b0;
                end else begin
                    rs_valid_s = 1'b1;
                    rs_byte_s  = status_s;
                end
            end
            SEQ_SEND: begin
                if (byte_ready_s) begin
                    if (pend_r != 2'd0) begin
                        byte_valid_s = 1'b1;
                        pend_s       = pend_r - 2'd1;
                        // Only the second byte of a two-data-byte message is data_byte2.
                        if ((pend_r == 2'd1) && (count_s == 2'd2)) begin
                            byte_data_s = to_data_byte(msg_r.data_byte2);
                        end else begin
                            byte_data_s = to_data_byte(msg_r.data_byte1);
                        end
                    end else begin
                        state_s = SEQ_IDLE;
                    end
                end else begin
                    state_s = SEQ_SEND;
                end
            end
            default: begin
                state_s = SEQ_IDLE;
            end
        endcase
    end

    // Sequencer, message and running-status registers plus registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= SEQ_IDLE;
            msg_r      <= '{message_type: SYSTEM, data_byte1: 7'd0, data_byte2: 7'd0};
            chan_r     <= {CHANNEL_WIDTH{1'b0}};
            pend_r     <= 2'd0;
            rs_valid_r <= 1'b0;
            rs_byte_r  <= 8'h00;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pend_r     <= pend_s;
            rs_valid_r <= rs_valid_s;
            rs_byte_r  <= rs_byte_s;
            ready_r    <= (state_s == SEQ_IDLE);
            busy_r     <= (state_s != SEQ_IDLE);
            if (msg_valid && ready_r) begin
                msg_r  <= message;
                chan_r <= channel;
            end
        end
    end

    midi_uart_tx #(
        .DIV (DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid_s),
        .byte_ready (byte_ready_s),
        .byte_data  (byte_data_s),
        .tx         (tx)
    );

endmodule

// File: tb/tb_midi_message_tx.sv
// Directed bench for midi_message_tx: decodes both MIDI OUT lines with a reference UART monitor.
module tb_midi_message_tx;
    import midi_message_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid0, valid1;
    message_t   message;
    logic [3:0] channel;
    logic       ready0, ready1, tx0, tx1, busy0, busy1;

    int pass_cnt = 0;
    int total    = 0;
    int frame_err  = 0;
    int timing_err = 0;
    int cyc = 0, hs0 = 0, hs_cyc = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    bit         mb[2]   = '{1'b0, 1'b0};
    int         mc[2]   = '{0, 0};
    logic [7:0] msh[2];
    int         run[2]  = '{0, 0};
    logic       last[2] = '{1'b1, 1'b1};

    always #5 clk = ~clk;

    midi_message_tx #(.CLK_FREQ(312_500), .RUNNING_STATUS(1)) dut (
        .clk(clk), .rst_n(rst_n), .msg_valid(valid0), .msg_ready(ready0),
        .message(message), .channel(channel), .tx(tx0), .busy(busy0));

    midi_message_tx #(.CLK_FREQ(312_500), .RUNNING_STATUS(0)) dut_nors (
        .clk(clk), .rst_n(rst_n), .msg_valid(valid1), .msg_ready(ready1),
        .message(message), .channel(channel), .tx(tx1), .busy(busy1));

    always @(posedge clk) begin
        cyc++;
        if (valid0 && ready0) begin
            hs0++;
            hs_cyc = cyc;
        end
    end

    // Reference UART receiver and low-run-length checker, sampled mid-cycle.
    always @(negedge clk) begin
        logic tv;
        for (int i = 0; i < 2; i++) begin
            tv = (i == 0) ? tx0 : tx1;
            if (!rst_n) begin
                mb[i] = 1'b0; run[i] = 0; last[i] = 1'b1;
            end else begin
                if (tv == last[i]) run[i]++;
                else begin
                    if (last[i] == 1'b0 && (run[i] % 10) != 0) timing_err++;
                    run[i] = 1; last[i] = tv;
                end
                if (!mb[i]) begin
                    if (tv == 1'b0) begin mb[i] = 1'b1; mc[i] = 0; end
                end else begin
                    mc[i]++;
                    if (mc[i] == 5) begin
                        if (tv !== 1'b0) frame_err++;
                    end else if (mc[i] >= 15 && mc[i] <= 85 && ((mc[i] - 5) % 10) == 0) begin
                        msh[i][(mc[i] - 15) / 10] = tv;
                    end else if (mc[i] == 95) begin
                        if (tv !== 1'b1) frame_err++;
                        if (i == 0) q0.push_back(msh[i]); else q1.push_back(msh[i]);
                        mb[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ready0 : ready1;
    endfunction

    function automatic logic txl(input int sel);
        return (sel == 0) ? tx0 : tx1;
    endfunction

    // Present a message, wait for acceptance, return #1 after the handshake edge.
    task automatic send(input int sel, input message_type_t t, input logic [6:0] d1,
                        input logic [6:0] d2, input logic [3:0] ch);
        int n = 0;
        @(negedge clk);
        message = '{message_type: t, data_byte1: d1, data_byte2: d2};
        channel = ch;
        if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
        while (rdy(sel) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_ready", rdy(sel), 1);
        @(posedge clk);
        #1;
        if (sel == 0) valid0 = 1'b0; else valid1 = 1'b0;
    endtask

    // Count edges until msg_ready returns; then the line must be idle high.
    task automatic wait_done(input int sel, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (rdy(sel) !== 1'b1 && n < 3000);
        chk("idle_high", txl(sel), 1);
    endtask

    task automatic pop_chk(input int sel, input string tag, input logic [7:0] exp);
        logic [31:0] obs;
        if (sel == 0) obs = (q0.size() > 0) ? {24'd0, q0.pop_front()} : 32'h100;
        else          obs = (q1.size() > 0) ? {24'd0, q1.pop_front()} : 32'h100;
        chk(tag, obs, {24'd0, exp});
    endtask

    initial begin
        int n;
        int first_cyc;
        int hs_before;
        rst_n   = 1'b0;
        valid0  = 1'b0;
        valid1  = 1'b0;
        message = '{message_type: NOTE_ON, data_byte1: 7'd0, data_byte2: 7'd0};
        channel = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx0, 1);
        chk("reset_ready", ready0, 1);
        chk("reset_busy", busy0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: NOTE_ON ch0 60/100
        send(0, NOTE_ON, 7'd60, 7'd100, 4'd0);
        chk("t1_ready_drop", ready0, 0);
        chk("t1_busy", busy0, 1);
        chk("t1_load_tx", tx0, 1);
        @(posedge clk);
        #1;
        chk("t1_start_bit", tx0, 0);
        wait_done(0, n);
        chk("t1_busy_cycles", n + 1, 301);
        pop_chk(0, "t1_b0", 8'h90);
        pop_chk(0, "t1_b1", 8'h3C);
        pop_chk(0, "t1_b2", 8'h64);
        chk("t1_q_empty", q0.size(), 0);

        // 2: running status skips 0x90
        send(0, NOTE_ON, 7'd64, 7'd0, 4'd0);
        wait_done(0, n);
        chk("t2_busy_cycles", n, 201);
        pop_chk(0, "t2_b0", 8'h40);
        pop_chk(0, "t2_b1", 8'h00);
        chk("t2_q_empty", q0.size(), 0);

        // 2b: same pair without running status
        send(1, NOTE_ON, 7'd60, 7'd100, 4'd0);
        wait_done(1, n);
        pop_chk(1, "t2n_a0", 8'h90);
        pop_chk(1, "t2n_a1", 8'h3C);
        pop_chk(1, "t2n_a2", 8'h64);
        send(1, NOTE_ON, 7'd64, 7'd0, 4'd0);
        wait_done(1, n);
        chk("t2n_busy_cycles", n, 301);
        pop_chk(1, "t2n_b0", 8'h90);
        pop_chk(1, "t2n_b1", 8'h40);
        pop_chk(1, "t2n_b2", 8'h00);
        chk("t2n_q_empty", q1.size(), 0);

        // 3: PROGRAM_CHANGE, SYSTEM, then status is resent
        send(0, PROGRAM_CHANGE, 7'd5, 7'h7F, 4'd3);
        wait_done(0, n);
        chk("t3_pc_cycles", n, 201);
        pop_chk(0, "t3_pc0", 8'hC3);
        pop_chk(0, "t3_pc1", 8'h05);
        chk("t3_pc_q_empty", q0.size(), 0);
        send(0, SYSTEM, 7'd0, 7'd0, 4'd2);
        wait_done(0, n);
        chk("t3_sys_cycles", n, 101);
        pop_chk(0, "t3_sys0", 8'hF2);
        chk("t3_sys_q_empty", q0.size(), 0);
        send(0, NOTE_ON, 7'd60, 7'd100, 4'd0);
        wait_done(0, n);
        chk("t3_non_cycles", n, 301);
        pop_chk(0, "t3_non0", 8'h90);
        pop_chk(0, "t3_non1", 8'h3C);
        pop_chk(0, "t3_non2", 8'h64);

        // 4: msg_valid held high across a busy frame
        hs_before = hs0;
        send(0, NOTE_OFF, 7'h10, 7'h20, 4'd1);
        first_cyc = hs_cyc;
        message = '{message_type: CONTROL_CHANGE, data_byte1: 7'd7, data_byte2: 7'h55};
        channel = 4'd1;
        valid0  = 1'b1;
        n = 0;
        while (ready0 !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_ready_back", ready0, 1);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        chk("t4_accept_cycle", hs_cyc - first_cyc, 302);
        wait_done(0, n);
        chk("t4_cc_cycles", n, 301);
        chk("t4_handshakes", hs0 - hs_before, 2);
        pop_chk(0, "t4_b0", 8'h81);
        pop_chk(0, "t4_b1", 8'h10);
        pop_chk(0, "t4_b2", 8'h20);
        pop_chk(0, "t4_b3", 8'hB1);
        pop_chk(0, "t4_b4", 8'h07);
        pop_chk(0, "t4_b5", 8'h55);
        chk("t4_q_empty", q0.size(), 0);

        // 5: reset during data bit 0 of byte 2
        send(0, NOTE_ON, 7'd60, 7'd100, 4'd0);
        repeat (115) @(posedge clk);
        #2;
        chk("t5_pre_reset_tx", tx0, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_tx", tx0, 1);
        chk("t5_reset_ready", ready0, 1);
        chk("t5_reset_busy", busy0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pop_chk(0, "t5_aborted_b0", 8'h90);
        chk("t5_abort_q_empty", q0.size(), 0);
        send(0, NOTE_ON, 7'd60, 7'd100, 4'd0);
        wait_done(0, n);
        chk("t5_cycles", n, 301);
        pop_chk(0, "t5_b0", 8'h90);
        pop_chk(0, "t5_b1", 8'h3C);
        pop_chk(0, "t5_b2", 8'h64);

        // 6: framing and bit timing over the whole run
        repeat (5) @(posedge clk);
        chk("t6_frame_errors", frame_err, 0);
        chk("t6_timing_errors", timing_err, 0);
        chk("t6_q0_empty", q0.size(), 0);
        chk("t6_q1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
